// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and FSM encoding for the PDM decimator.
// Provides CIC order, PCM width, accumulator width helper and states.
package audio_pkg;

    localparam int CIC_ORDER = 3;
    localparam int PCM_W     = 16;

    // Accumulator width that lets R^3 growth wrap safely.
    function automatic int acc_w(input int decim_log2);
        return CIC_ORDER * decim_log2 + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } cic_state_e;

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one CIC comb section, y = x - x_delayed.
// The delay register loads only on decimation events.
module cic_comb_stage
    import audio_pkg::*;
#(
    parameter int W = acc_w(6)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    logic [W-1:0] dly;

    assign y = x - dly;

    // Hold the previous decimated input; cleared while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly <= '0;
        end else if (clr) begin
            dly <= '0;
        end else if (en) begin
            dly <= x;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: 1-bit PDM stream to 16-bit PCM via a 3rd-order CIC.
// Define PDM_CLK_GEN_EN to generate the PDM bit clock internally.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 6,
    parameter int CLK_DIV    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    pdm_i,
    input  logic                    pdm_strobe_i,
    output logic                    pdm_clk_o,
    output logic signed [PCM_W-1:0] sample_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o
);

    localparam int ACC_W = acc_w(DECIM_LOG2);
    localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - (PCM_W - 1);
    localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] PCM_MIN = ACC_W'(-32768);

    logic             pdm_meta;
    logic             pdm_sync;
    logic             bit_strobe;
    logic             dec_evt;
    logic             clr;
    logic [ACC_W-1:0] x_in;
    logic [ACC_W-1:0] integ1, integ2, integ3;
    logic [ACC_W-1:0] in1, in2, in3;
    logic [ACC_W-1:0] comb1, comb2, comb3;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic signed [ACC_W-1:0] scaled;
    logic [PCM_W-1:0] pcm;
    cic_state_e       state;
    logic             warm_cnt;

    assign clr = !enable_i;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pdm_meta <= 1'b0;
            pdm_sync <= 1'b0;
        end else begin
            pdm_meta <= pdm_i;
            pdm_sync <= pdm_meta;
        end
    end

`ifdef PDM_CLK_GEN_EN
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             pdm_clk;
    logic             unused_strobe;

    assign unused_strobe = pdm_strobe_i;
    assign div_nxt = (!enable_i || div_cnt == DIV_W'(CLK_DIV - 1))
                   ? '0 : div_cnt + DIV_W'(1);

    // Bit-clock divider; the clock is high for the upper half count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pdm_clk <= (div_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

    assign pdm_clk_o  = pdm_clk;
    assign bit_strobe = enable_i && (div_cnt == DIV_W'(CLK_DIV - 1));
`else
    logic unused_div;

    assign unused_div = (CLK_DIV >= 4);
    assign pdm_clk_o  = 1'b0;
    assign bit_strobe = pdm_strobe_i && enable_i;
`endif

    assign x_in = pdm_sync ? ACC_W'(1) : '1;
    assign in1  = integ1 + x_in;
    assign in2  = integ2 + in1;
    assign in3  = integ3 + in2;

    assign dec_evt = bit_strobe && (dec_cnt == '1);

    // Integrators and decimation counter advance on each bit strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            dec_cnt <= '0;
        end else if (!enable_i) begin
            integ1  <= '0;
            integ2  <= '0;
            integ3  <= '0;
            dec_cnt <= '0;
        end else if (bit_strobe) begin
            integ1  <= in1;
            integ2  <= in2;
            integ3  <= in3;
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    cic_comb_stage #(.W(ACC_W)) u_comb1 (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr),
        .en  (dec_evt),
        .x   (in3),
        .y   (comb1)
    );

    cic_comb_stage #(.W(ACC_W)) u_comb2 (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr),
        .en  (dec_evt),
        .x   (comb1),
        .y   (comb2)
    );

    cic_comb_stage #(.W(ACC_W)) u_comb3 (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clr),
        .en  (dec_evt),
        .x   (comb2),
        .y   (comb3)
    );

    assign scaled = $signed(comb3) >>> SHIFT;

    // Saturate the scaled comb output to the PCM range.
    always_comb begin
        pcm = scaled[PCM_W-1:0];
        if (scaled > PCM_MAX) begin
            pcm = PCM_MAX[PCM_W-1:0];
        end else if (scaled < PCM_MIN) begin
            pcm = PCM_MIN[PCM_W-1:0];
        end
    end

    // Warm-up sequencing and the valid/ready output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            warm_cnt   <= 1'b0;
            sample_o   <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (!enable_i) begin
            state      <= IDLE;
            warm_cnt   <= 1'b0;
            sample_o   <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= WARMUP;
                    warm_cnt <= 1'b0;
                end
                WARMUP: begin
                    if (dec_evt) begin
                        warm_cnt <= 1'b1;
                        if (warm_cnt) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (dec_evt) begin
                        sample_o <= pcm;
                        valid_o  <= 1'b1;
                        if (valid_o && !ready_i) begin
                            overflow_o <= 1'b1;
                        end
                    end else if (valid_o && ready_i) begin
                        valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed self-checking bench for pdm_decimator.
// Works with or without PDM_CLK_GEN_EN defined.
`timescale 1ns/1ps
module tb_pdm_decimator;

`ifdef PDM_CLK_GEN_EN
    localparam int BIT_CLK = 16;
`else
    localparam int BIT_CLK = 5;
`endif
    localparam int R     = 64;
    localparam int FRAME = R * BIT_CLK;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic pdm_i = 1'b1;
    logic pdm_strobe;
    logic pdm_clk;
    logic signed [15:0] sample;
    logic valid;
    logic ready;
    logic overflow;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [3:0] pat  = 4'b1111;
    int         plen = 4;
    int         pidx = 0;

    pdm_decimator #(
        .DECIM_LOG2 (6),
        .CLK_DIV    (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .pdm_i        (pdm_i),
        .pdm_strobe_i (pdm_strobe),
        .pdm_clk_o    (pdm_clk),
        .sample_o     (sample),
        .valid_o      (valid),
        .ready_i      (ready),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External strobe: one cycle high every 5 clocks.
    initial begin
        pdm_strobe = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            pdm_strobe = 1'b1;
            @(negedge clk);
            pdm_strobe = 1'b0;
        end
    end

    // Present the next pattern bit just after each sampled bit.
    initial begin
        forever begin
`ifdef PDM_CLK_GEN_EN
            @(negedge pdm_clk);
`else
            do @(posedge clk); while (!pdm_strobe);
`endif
            #1;
            pdm_i = pat[pidx % plen];
            pidx  = pidx + 1;
        end
    end

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_sample(input string tag,
                              output logic signed [15:0] s,
                              output int t);
        logic ok;
        wait_valid(ok);
        check({tag, "_seen"}, ok, 1);
        s = sample;
        t = cyc;
    endtask

    task automatic measure_first(input string tag);
        int   n    = 0;
        int   bits = 0;
        logic seen = 1'b0;
        logic hi   = 1'b0;
        while (n < 4 * 3 * FRAME) begin
            @(posedge clk);
            n++;
            if (pdm_strobe) bits++;
            #1;
`ifdef PDM_CLK_GEN_EN
            if (n == 7)  check({tag, "_pclk7"}, pdm_clk, 0);
            if (n == 8)  check({tag, "_pclk8"}, pdm_clk, 1);
            if (n == 16) check({tag, "_pclk16"}, pdm_clk, 0);
`else
            if (pdm_clk) hi = 1'b1;
`endif
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, seen, 1);
`ifdef PDM_CLK_GEN_EN
        check({tag, "_latency"}, n, 3 * FRAME);
`else
        check({tag, "_bits"}, bits, 3 * R);
        check({tag, "_pclk_low"}, hi, 0);
`endif
    endtask

    initial begin
        logic signed [15:0] s;
        int t0;
        int t1;
        logic ok;

        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pclk", pdm_clk, 0);
        check("rst_sample", sample, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // all ones: full scale positive saturates
        enable = 1'b1;
        measure_first("t1");
        check("t1_sample", sample, 32767);

        // all zeros: full scale negative, steady cadence
        pat = 4'b0000;
        repeat (3) get_sample("t2_skip", s, t0);
        get_sample("t2_a", s, t0);
        check("t2_sample_a", s, -32768);
        get_sample("t2_b", s, t1);
        check("t2_sample_b", s, -32768);
        check("t2_interval", t1 - t0, FRAME);
        check("t2_ovf", overflow, 0);

        // alternating bits average to zero
        pat  = 4'b1010;
        plen = 2;
        repeat (3) get_sample("t3_skip", s, t0);
        get_sample("t3_alt", s, t0);
        check("t3_alt_sample", s, 0);

        // one in four ones: mean -0.5 of full scale
        pat  = 4'b0001;
        plen = 4;
        repeat (3) get_sample("t3_skip", s, t0);
        get_sample("t3_q", s, t0);
        check("t3_quarter_a", s, -16384);
        get_sample("t3_q", s, t0);
        check("t3_quarter_b", s, -16384);

        // back-pressure: overwrite sets sticky overflow
        pat = 4'b1111;
        repeat (3) get_sample("t4_skip", s, t0);
        get_sample("t4_pos", s, t0);
        check("t4_pos_sample", s, 32767);
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        wait_valid(ok);
        check("t4_first_seen", ok, 1);
        check("t4_ovf_first", overflow, 0);
        pat = 4'b0000;
        repeat (FRAME) @(posedge clk);
        #1;
        check("t4_ovf_set", overflow, 1);
        check("t4_valid_held", valid, 1);
        repeat (5 * FRAME) @(posedge clk);
        #1;
        check("t4_newest", sample, -32768);
        check("t4_valid_still", valid, 1);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_valid_drop", valid, 0);
        check("t4_ovf_sticky", overflow, 1);

        // disable mid-frame clears everything and restarts warm-up
        pat = 4'b1111;
        repeat (100) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("t5_ovf_clr", overflow, 0);
        check("t5_valid_clr", valid, 0);
        check("t5_pclk_clr", pdm_clk, 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        measure_first("t5");
        check("t5_sample", sample, 32767);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
